pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Drives write-enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Handles three events: load-use stalls, taken-branch squash (branch resolves in MEM), and a multi-cycle data-memory wait with timeout. Sits beside the datapath and reads only decoded fields from ID, ID/EX and EX/MEM.

---
 rtl/pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer (optional stall counter: HAZ_PERF_CNT_EN)
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  idex_rt,
    input  logic        idex_memread,
    input  logic        exmem_branch,
    input  logic        exmem_zf,
    input  logic        exmem_bne,
    input  logic        exmem_memreq,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_write,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_error,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_lu_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_mem_error;

    logic w_taken;
    logic w_hazard;
    logic w_mem_wait;
    logic w_timeout;

    assign w_taken    = exmem_branch & (exmem_zf ^ exmem_bne);
    assign w_hazard   = idex_memread & (idex_rt != 5'd0) &
                        ((idex_rt == id_rs) | (idex_rt == id_rt));
    assign w_mem_wait = exmem_memreq & ~mem_ready;
    assign w_timeout  = (r_wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign mem_error  = r_mem_error;

    // Combinational enables/flushes from state and decoded hazard events; all low in reset
    always_comb begin
        pc_write    = 1'b1;
        pc_src      = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_wait) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                        memwb_flush = 1'b1;
                    end else if (w_taken) begin
                        pc_src      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (w_hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_flush  = 1'b1;
                    end
                end
                S_LU_STALL: begin
                    if (w_mem_wait) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                        memwb_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_flush  = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    // A timeout releases the access exactly like a ready would
                    if (!mem_ready && !w_timeout) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                        memwb_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, load-use bubble counter, memory wait counter and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_lu_cnt    <= 3'd0;
            r_wait_cnt  <= 8'd0;
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end else if (!w_taken && w_hazard && (LOAD_STALL_CYCLES > 1)) begin
                        r_state  <= S_LU_STALL;
                        r_lu_cnt <= 3'(LOAD_STALL_CYCLES - 1);
                    end
                end
                S_LU_STALL: begin
                    if (w_mem_wait) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                        r_lu_cnt   <= 3'd0;
                    end else if (r_lu_cnt == 3'd1) begin
                        r_state  <= S_RUN;
                        r_lu_cnt <= 3'd0;
                    end else begin
                        r_lu_cnt <= r_lu_cnt - 3'd1;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (w_timeout) begin
                        r_state     <= S_RUN;
                        r_wait_cnt  <= 8'd0;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
        end else if (!pc_write && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    // Output vector order: pc_write,pc_src,ifid_write,ifid_flush,idex_write,idex_flush,exmem_write,exmem_flush,memwb_flush
    localparam logic [8:0] DEF   = 9'b1_0_1_0_1_0_1_0_0;
    localparam logic [8:0] STALL = 9'b0_0_0_0_1_1_1_0_0;
    localparam logic [8:0] TAKEN = 9'b1_1_1_1_1_1_1_1_0;
    localparam logic [8:0] FRZ   = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] ZERO  = 9'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       idex_memread, exmem_branch, exmem_zf, exmem_bne, exmem_memreq, mem_ready;

    logic        a_pcw, a_pcs, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf, a_mwf, a_err;
    logic [15:0] a_cnt;
    logic        b_pcw, b_pcs, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf, b_mwf, b_err;
    logic [15:0] b_cnt;
    logic [8:0]  a_out, b_out;

    assign a_out = {a_pcw, a_pcs, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf, a_mwf};
    assign b_out = {b_pcw, b_pcs, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf, b_mwf};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .idex_rt(idex_rt),
        .idex_memread(idex_memread), .exmem_branch(exmem_branch), .exmem_zf(exmem_zf),
        .exmem_bne(exmem_bne), .exmem_memreq(exmem_memreq), .mem_ready(mem_ready),
        .pc_write(a_pcw), .pc_src(a_pcs), .ifid_write(a_ifw), .ifid_flush(a_iff),
        .idex_write(a_idw), .idex_flush(a_idf), .exmem_write(a_exw), .exmem_flush(a_exf),
        .memwb_flush(a_mwf), .mem_error(a_err), .stall_cycles(a_cnt)
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .idex_rt(idex_rt),
        .idex_memread(idex_memread), .exmem_branch(exmem_branch), .exmem_zf(exmem_zf),
        .exmem_bne(exmem_bne), .exmem_memreq(exmem_memreq), .mem_ready(mem_ready),
        .pc_write(b_pcw), .pc_src(b_pcs), .ifid_write(b_ifw), .ifid_flush(b_iff),
        .idex_write(b_idw), .idex_flush(b_idf), .exmem_write(b_exw), .exmem_flush(b_exf),
        .memwb_flush(b_mwf), .mem_error(b_err), .stall_cycles(b_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt, xrt;
        logic       memrd, br, zf, bne, mreq, rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add_vec(input string n, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] xrt, input logic memrd, input logic br,
                           input logic zf, input logic bne, input logic mreq,
                           input logic rdy, input logic [8:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.xrt = xrt; v.memrd = memrd; v.br = br;
        v.zf = zf; v.bne = bne; v.mreq = mreq; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                          input logic memrd, input logic br, input logic zf, input logic bne,
                          input logic mreq, input logic rdy);
        id_rs = rs; id_rt = rt; idex_rt = xrt; idex_memread = memrd; exmem_branch = br;
        exmem_zf = zf; exmem_bne = bne; exmem_memreq = mreq; mem_ready = rdy;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later
    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic do_reset;
        cyc();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //       name             rs  rt  xrt memrd br zf bne mreq rdy exp
        add_vec("idle",           0,  0,  0,  0,   0, 0, 0,  0,   0,  DEF);
        add_vec("lu_rs",          8,  3,  8,  1,   0, 0, 0,  0,   0,  STALL);
        add_vec("lu_rt",          4,  8,  8,  1,   0, 0, 0,  0,   0,  STALL);
        add_vec("lu_r0",          0,  0,  0,  1,   0, 0, 0,  0,   0,  DEF);
        add_vec("no_load_match",  8,  8,  8,  0,   0, 0, 0,  0,   0,  DEF);
        add_vec("lu_no_match",    5,  6,  8,  1,   0, 0, 0,  0,   0,  DEF);
        add_vec("beq_taken",      0,  0,  0,  0,   1, 1, 0,  0,   0,  TAKEN);
        add_vec("bne_zf1",        0,  0,  0,  0,   1, 1, 1,  0,   0,  DEF);
        add_vec("bne_taken",      0,  0,  0,  0,   1, 0, 1,  0,   0,  TAKEN);
        add_vec("zf_no_branch",   0,  0,  0,  0,   0, 1, 0,  0,   0,  DEF);
        add_vec("taken_and_lu",   8,  0,  8,  1,   1, 1, 0,  0,   0,  TAKEN);
        add_vec("memreq_ready",   0,  0,  0,  0,   0, 0, 0,  1,   1,  DEF);
        add_vec("ready_no_req",   0,  0,  0,  0,   0, 0, 0,  0,   1,  DEF);

        // Reset state
        #1;
        chk("reset_outs", a_out, ZERO);
        chk("reset_err", a_err, 0);
        chk("reset_cnt", a_cnt, 0);
        cyc();
        rst = 1'b0;

        // Single-cycle RUN decisions on the LOAD_STALL_CYCLES=1 instance
        foreach (vecs[i]) begin
            cyc();
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].xrt, vecs[i].memrd, vecs[i].br,
                   vecs[i].zf, vecs[i].bne, vecs[i].mreq, vecs[i].rdy);
            #1 chk(vecs[i].name, a_out, vecs[i].exp);
        end

        // Load-use: one bubble on dut_a, three on dut_b
        do_reset();
        cyc(); set_in(8, 0, 8, 1, 0, 0, 0, 0, 0);
        #1 chk("lu1_a_c1", a_out, STALL);
        chk("lu3_b_c1", b_out, STALL);
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("lu1_a_c2", a_out, DEF);
        chk("lu3_b_c2", b_out, STALL);
        cyc(); #1 chk("lu3_b_c3", b_out, STALL);
        cyc(); #1 chk("lu3_b_c4", b_out, DEF);
`ifdef HAZ_PERF_CNT_EN
        chk("lu3_b_cnt", b_cnt, 3);
`else
        chk("cnt_tied0", b_cnt, 0);
`endif

        // Memory wait of 4 cycles then ready
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            #1 chk($sformatf("mw_frz%0d", i), a_out, FRZ);
        end
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1 chk("mw_ready", a_out, DEF);
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("mw_after", a_out, DEF);
        chk("mw_no_err", a_err, 0);

        // Timeout: 15 frozen cycles, release on the 16th, sticky error
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            #1 chk($sformatf("to_frz%0d", i), a_out, FRZ);
        end
        cyc(); #1 chk("to_release", a_out, DEF);
        chk("to_err_pre", a_err, 0);
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("to_err", a_err, 1);
        chk("to_after", a_out, DEF);
        cyc(); cyc(); #1 chk("to_err_sticky", a_err, 1);
        do_reset();
        #1 chk("to_err_cleared", a_err, 0);

        // Memory wait arising in LU_STALL discards the remaining bubbles
        do_reset();
        cyc(); set_in(8, 0, 8, 1, 0, 0, 0, 0, 0);
        #1 chk("lum_c1", b_out, STALL);
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 chk("lum_frz", b_out, FRZ);
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1 chk("lum_ready", b_out, DEF);
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("lum_run", b_out, DEF);

        // Asynchronous reset in the middle of a memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        cyc(); rst = 1'b1;
        #1 chk("rstw_outs_a", a_out, ZERO);
        chk("rstw_outs_b", b_out, ZERO);
        chk("rstw_cnt", a_cnt, 0);
        cyc(); rst = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("rstw_run", a_out, DEF);
        chk("rstw_cnt2", a_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
